phone_key_scheduler: RTL and testbench

PHONE_KEY_SCHEDULER -- requirements
Module: phone_key_scheduler

---
 rtl/phone_pkg.sv | 19 +
 rtl/key_fifo.sv | 54 +++++
 rtl/phone_key_scheduler.sv | 145 ++++++++++++++
 tb/tb_phone_key_scheduler.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/phone_pkg.sv
// Shared types and timing constants for the phone keypad scheduler.
package phone_pkg;

  localparam int unsigned DIGIT_W    = 4;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned REDIAL_LEN = 4;
  localparam int unsigned HOLD_CYC   = 2;
  localparam int unsigned GAP_CYC    = 1;
  localparam int unsigned CNT_W      = 4;

  typedef enum logic [2:0] {
    IDLE,
    PRESS,
    HOLD,
    RELEASE,
    GAP
  } seq_state_t;

endpackage

// File: rtl/key_fifo.sv
// Small synchronous FIFO buffering keypad digits ahead of the sequencer.
module key_fifo
  import phone_pkg::*;
#(
  parameter int unsigned DEPTH = FIFO_DEPTH,
  parameter int unsigned W     = DIGIT_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [W-1:0]                 din,
  input  logic                         pop,
  output logic [W-1:0]                 dout,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == PW'(DEPTH-1)) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == PW'(DEPTH-1)) ? '0 : rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/phone_key_scheduler.sv
// Sequences buffered keypad digits into press/hold/release/gap strobes and
// keeps the last four dialled digits for redial replay.
module phone_key_scheduler
  import phone_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               kp_valid,
  input  logic [DIGIT_W-1:0] kp_char,
  output logic               kp_ready,
  input  logic               rd_start,
  output logic               Keypressed,
  output logic               Keyreleased,
  output logic [DIGIT_W-1:0] charSent,
  output logic               busy,
  output logic [2:0]         rd_count
);

  localparam int unsigned RI_W = $clog2(REDIAL_LEN);

  seq_state_t         state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic               redial_mode, redial_n;
  logic [2:0]         rd_idx, rd_idx_n;
  logic [DIGIT_W-1:0] rd_buf [REDIAL_LEN];

  logic               push;
  logic               pop;
  logic               load;
  logic [DIGIT_W-1:0] load_val;
  logic               record;
  logic               rd_accept;

  logic [DIGIT_W-1:0] fifo_dout;
  logic               fifo_full;
  logic               fifo_empty;
  logic [2:0]         fifo_count;

  key_fifo #(.DEPTH(FIFO_DEPTH), .W(DIGIT_W)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (kp_char),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign kp_ready    = !fifo_full && !redial_mode;
  assign push        = kp_valid && kp_ready;
  assign Keypressed  = (state == PRESS);
  assign Keyreleased = (state == RELEASE);
  assign busy        = (state != IDLE) || redial_mode;

  // A same-cycle push leaves the FIFO non-empty next cycle, so it beats redial.
  assign rd_accept = rd_start && (state == IDLE) && (fifo_count == '0) &&
                     !redial_mode && (rd_count != '0) && !push;

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    redial_n = redial_mode;
    rd_idx_n = rd_idx;
    pop      = 1'b0;
    load     = 1'b0;
    load_val = '0;
    record   = 1'b0;
    case (state)
      IDLE: begin
        if (redial_mode) begin
          load     = 1'b1;
          load_val = rd_buf[rd_idx[RI_W-1:0]];
          rd_idx_n = rd_idx + 1'b1;
          state_n  = PRESS;
        end else if (!fifo_empty) begin
          pop      = 1'b1;
          load     = 1'b1;
          load_val = fifo_dout;
          record   = 1'b1;
          state_n  = PRESS;
        end else if (rd_accept) begin
          redial_n = 1'b1;
          rd_idx_n = '0;
        end
      end
      PRESS: begin
        cnt_n   = '0;
        state_n = HOLD;
      end
      HOLD: begin
        if (cnt == CNT_W'(HOLD_CYC-1)) begin
          cnt_n   = '0;
          state_n = RELEASE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      RELEASE: begin
        cnt_n   = '0;
        state_n = GAP;
      end
      GAP: begin
        if (cnt == CNT_W'(GAP_CYC-1)) begin
          cnt_n   = '0;
          state_n = IDLE;
          if (redial_mode && (rd_idx == rd_count)) redial_n = 1'b0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      redial_mode <= 1'b0;
      rd_idx      <= '0;
      rd_count    <= '0;
      charSent    <= '0;
      for (int unsigned i = 0; i < REDIAL_LEN; i++) rd_buf[i] <= '0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      redial_mode <= redial_n;
      rd_idx      <= rd_idx_n;
      if (load) charSent <= load_val;
      // Oldest entry stays at index 0 so replay simply walks upward.
      if (record) begin
        if (rd_count < 3'(REDIAL_LEN)) begin
          rd_buf[rd_count[RI_W-1:0]] <= fifo_dout;
          rd_count <= rd_count + 1'b1;
        end else begin
          for (int unsigned i = 0; i < REDIAL_LEN-1; i++) rd_buf[i] <= rd_buf[i+1];
          rd_buf[REDIAL_LEN-1] <= fifo_dout;
        end
      end
    end
  end

endmodule

// File: tb/tb_phone_key_scheduler.sv
// Self-checking bench: table vectors, directed corner sequences and random
// stimulus compared against a key-timeline reference model.
module tb_phone_key_scheduler;
  import phone_pkg::*;

  logic       clk = 1'b0;
  logic       rst, kp_valid, rd_start;
  logic [3:0] kp_char;
  logic       kp_ready, Keypressed, Keyreleased, busy;
  logic [3:0] charSent;
  logic [2:0] rd_count;

  always #5 clk = ~clk;

  phone_key_scheduler dut (
    .clk(clk), .rst(rst), .kp_valid(kp_valid), .kp_char(kp_char),
    .kp_ready(kp_ready), .rd_start(rd_start), .Keypressed(Keypressed),
    .Keyreleased(Keyreleased), .charSent(charSent), .busy(busy),
    .rd_count(rd_count)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Reference model: a key is a timeline of LAST+1 cycles starting at press.
  localparam int REL  = HOLD_CYC + 1;
  localparam int LAST = HOLD_CYC + 1 + GAP_CYC;
  int q_fifo[$];
  int hist[$];
  int age   = -1;
  int cur   = 0;
  bit rmode = 0;
  int ridx  = 0;

  int press_d[$];
  int press_t[$];
  int rel_n = 0;

  function automatic bit m_rdy();
    return (q_fifo.size() < FIFO_DEPTH) && !rmode;
  endfunction

  function automatic bit m_busy();
    return (age >= 0) || rmode;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_next();
    bit p;
    if (rst) begin
      q_fifo.delete(); hist.delete();
      age = -1; cur = 0; rmode = 0; ridx = 0;
    end else begin
      p = kp_valid && m_rdy();
      if (age < 0) begin
        if (rmode) begin
          cur = hist[ridx]; ridx++; age = 0;
        end else if (q_fifo.size() > 0) begin
          cur = q_fifo.pop_front();
          hist.push_back(cur);
          if (hist.size() > REDIAL_LEN) void'(hist.pop_front());
          age = 0;
        end else if (rd_start && !p && hist.size() > 0) begin
          rmode = 1; ridx = 0;
        end
      end else if (age == LAST) begin
        age = -1;
        if (rmode && ridx == hist.size()) rmode = 0;
      end else begin
        age++;
      end
      if (p) q_fifo.push_back(int'(kp_char));
    end
  endtask

  task automatic check_all();
    cmp("kp_ready",    kp_ready,    m_rdy());
    cmp("Keypressed",  Keypressed,  age == 0);
    cmp("Keyreleased", Keyreleased, age == REL);
    cmp("charSent",    charSent,    cur);
    cmp("busy",        busy,        m_busy());
    cmp("rd_count",    rd_count,    hist.size());
    cmp("strobe_excl", Keypressed && Keyreleased, 1'b0);
    if (Keypressed) begin
      press_d.push_back(int'(charSent));
      press_t.push_back(cyc);
    end
    if (Keyreleased) rel_n++;
  endtask

  task automatic tick();
    @(posedge clk);
    model_next();
    #1;
    cyc++;
    check_all();
  endtask

  task automatic drive(input bit v, input int c, input bit rs, input bit r);
    kp_valid = v; kp_char = 4'(c); rd_start = rs; rst = r;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 1); tick();
    drive(0, 0, 0, 0);
  endtask

  task automatic wait_idle(input int limit);
    int t;
    t = 0;
    drive(0, 0, 0, 0);
    while ((m_busy() || q_fifo.size() > 0) && t < limit) begin
      tick(); t++;
    end
    if (m_busy() || q_fifo.size() > 0) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_idle timeout at cycle %0d after %0d cycles", cyc, t);
    end
  endtask

  task automatic clear_log();
    press_d.delete(); press_t.delete(); rel_n = 0;
  endtask

  typedef struct {
    bit       r;
    bit       v;
    bit [3:0] c;
    bit       rs;
    bit       kp;
    bit       kr;
    bit [3:0] cs;
    bit       bz;
    bit       rdy;
    bit [2:0] rdc;
  } vec_t;

  vec_t vt[15];

  initial begin
    int t;
    drive(0, 0, 0, 1);

    // r, v, c, rs -> Keypressed, Keyreleased, charSent, busy, kp_ready, rd_count
    vt[0]  = '{1, 0, 0, 0, 0, 0, 0, 0, 1, 0};
    vt[1]  = '{0, 1, 1, 0, 0, 0, 0, 0, 1, 0};
    vt[2]  = '{0, 0, 0, 0, 1, 0, 1, 1, 1, 1};
    vt[3]  = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 1};
    vt[4]  = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 1};
    vt[5]  = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 1};
    vt[6]  = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 1};
    vt[7]  = '{0, 0, 0, 0, 0, 0, 1, 0, 1, 1};
    vt[8]  = '{0, 0, 0, 1, 0, 0, 1, 1, 0, 1};
    vt[9]  = '{0, 0, 0, 0, 1, 0, 1, 1, 0, 1};
    vt[10] = '{0, 0, 0, 0, 0, 0, 1, 1, 0, 1};
    vt[11] = '{0, 0, 0, 0, 0, 0, 1, 1, 0, 1};
    vt[12] = '{0, 0, 0, 0, 0, 1, 1, 1, 0, 1};
    vt[13] = '{0, 0, 0, 0, 0, 0, 1, 1, 0, 1};
    vt[14] = '{0, 0, 0, 0, 0, 0, 1, 0, 1, 1};

    @(negedge clk);
    for (int i = 0; i < 15; i++) begin
      drive(vt[i].v, int'(vt[i].c), vt[i].rs, vt[i].r);
      tick();
      cmp("tbl_kp",  Keypressed,  vt[i].kp);
      cmp("tbl_kr",  Keyreleased, vt[i].kr);
      cmp("tbl_cs",  charSent,    vt[i].cs);
      cmp("tbl_bz",  busy,        vt[i].bz);
      cmp("tbl_rdy", kp_ready,    vt[i].rdy);
      cmp("tbl_rdc", rd_count,    vt[i].rdc);
    end

    // Five consecutive pushes fill the FIFO; a sixth waits for the first pop.
    do_reset(); clear_log();
    for (int d = 1; d <= 6; d++) begin
      t = 0;
      if (d == 6) cmp("full_refuse", kp_ready, 1'b0);
      drive(0, 0, 0, 0);
      while (!kp_ready && t < 20) begin tick(); t++; end
      if (d == 6) cmp("full_wait", t, 3);
      drive(1, d, 0, 0); tick();
    end
    wait_idle(80);
    cmp("seq_len", press_d.size(), 6);
    for (int i = 0; i < press_d.size() && i < 6; i++) begin
      cmp("seq_digit", press_d[i], i + 1);
      if (i > 0) cmp("seq_spacing", press_t[i] - press_t[i-1], 6);
    end

    // Redial replay of 3,2,3,4.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1, (i == 0) ? 3 : (i == 1) ? 2 : (i == 2) ? 3 : 4, 0, 0); tick();
    end
    wait_idle(60);
    clear_log();
    drive(0, 0, 1, 0); tick();
    cmp("redial_busy", busy, 1'b1);
    wait_idle(60);
    cmp("redial_len", press_d.size(), 4);
    if (press_d.size() == 4) begin
      cmp("redial_d0", press_d[0], 3);
      cmp("redial_d1", press_d[1], 2);
      cmp("redial_d2", press_d[2], 3);
      cmp("redial_d3", press_d[3], 4);
    end
    cmp("redial_rdc", rd_count, 3'd4);

    // rd_start while busy is ignored.
    clear_log();
    drive(1, 9, 0, 0); tick();
    drive(0, 0, 0, 0); tick(); tick();
    drive(0, 0, 1, 0); tick();
    wait_idle(60);
    cmp("busy_rd_len", press_d.size(), 1);

    // rd_start with an empty redial buffer is ignored.
    do_reset(); clear_log();
    drive(0, 0, 1, 0); tick();
    cmp("rd_empty_busy", busy, 1'b0);
    drive(0, 0, 0, 0);
    for (int i = 0; i < 6; i++) tick();
    cmp("rd_empty_press", press_d.size(), 0);

    // Reset during HOLD of digit 7 aborts without a release.
    do_reset(); clear_log();
    drive(1, 7, 0, 0); tick();
    drive(0, 0, 0, 0); tick(); tick();
    cmp("hold7_kp_seen", press_d.size(), 1);
    drive(0, 0, 0, 1); tick();
    cmp("abort_cs",  charSent, 4'd0);
    cmp("abort_rdc", rd_count, 3'd0);
    cmp("abort_rdy", kp_ready, 1'b1);
    drive(0, 0, 0, 0);
    for (int i = 0; i < 8; i++) tick();
    cmp("abort_no_release", rel_n, 0);
    cmp("abort_no_press",   press_d.size(), 1);

    // Push and rd_start together from idle: the push wins.
    drive(1, 5, 0, 0); tick();
    wait_idle(30);
    clear_log();
    drive(1, 6, 1, 0); tick();
    wait_idle(40);
    cmp("push_wins_len", press_d.size(), 1);
    if (press_d.size() == 1) cmp("push_wins_d", press_d[0], 6);
    cmp("push_wins_rdc", rd_count, 3'd2);

    // Random traffic.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 2) != 0, int'($urandom_range(0, 15)),
            $urandom_range(0, 11) == 0, $urandom_range(0, 400) == 0);
      tick();
    end
    wait_idle(80);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
